// File: rtl/spi_mem_subsys.sv
// rtl/spi_mem_subsys.sv - host command port, SPI controller and SPI register-array memory over an internal 4-wire link
module spi_mem_subsys #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 32,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic              ready,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic              err,
    output logic              spi_cs_n,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic              spi_miso
);

    localparam int TXW  = 1 + ADDR_W + DATA_W;
    localparam int PW   = $clog2(2 * CLK_DIV);
    localparam int MAXB = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
    localparam int CW   = $clog2(MAXB + 1);
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Phase counter values: last cycle of a bit period, last low cycle, first high cycle
    localparam logic [PW-1:0]     P_LAST  = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0]     P_HI    = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]     P_SAMP  = PW'(CLK_DIV);
    localparam logic [CW-1:0]     B_ADDR  = CW'(ADDR_W);
    localparam logic [CW-1:0]     B_DATA  = CW'(DATA_W - 1);
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, CMD, WDATA, TA, RDATA, DONE, ERR} c_state_t;
    typedef enum logic [2:0] {M_IDLE, M_CMD, M_WDATA, M_TA, M_RDATA} m_state_t;

    c_state_t          c_state;
    logic              wr_q;
    logic [TXW-1:0]    tx;
    logic [PW-1:0]     pcnt;
    logic [CW-1:0]     bcnt;
    logic [DATA_W-1:0] rx;
    logic [DATA_W-1:0] rx_next;
    logic              cs_n_r;
    logic              sclk_r;

    m_state_t          m_state;
    logic              cs_prev;
    logic              sclk_prev;
    logic [CW-1:0]     m_cnt;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_sh;
    logic              miso_r;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              mosi_w;
    logic              s_rise;
    logic              s_fall;
    logic              m_ok;
    logic [IW-1:0]     m_idx;

    assign mosi_w   = tx[TXW-1];
    assign spi_cs_n = cs_n_r;
    assign spi_sclk = sclk_r;
    assign spi_mosi = mosi_w;
    assign spi_miso = miso_r;

    assign s_rise = sclk_r & ~sclk_prev;
    assign s_fall = ~sclk_r & sclk_prev;
    assign m_ok   = ({1'b0, m_addr} < DEPTH_V);
    assign m_idx  = m_addr[IW-1:0];

    // Controller receive shifter: sample miso in the first sclk-high cycle of each read data bit
    always_comb begin
        rx_next = rx;
        if (c_state == RDATA && pcnt == P_SAMP)
            rx_next = {rx[DATA_W-2:0], miso_r};
    end

    // Controller FSM: request accept, range check, frame sequencing and sclk generation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_state <= IDLE;
            wr_q    <= 1'b0;
            tx      <= '0;
            pcnt    <= '0;
            bcnt    <= '0;
            rx      <= '0;
            cs_n_r  <= 1'b1;
            sclk_r  <= 1'b0;
            ready   <= 1'b1;
            dout    <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (c_state)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (req && ready) begin
                        ready <= 1'b0;
                        wr_q  <= wr;
                        if ({1'b0, addr} >= DEPTH_V) begin
                            done    <= 1'b1;
                            err     <= 1'b1;
                            c_state <= ERR;
                        end else begin
                            cs_n_r  <= 1'b0;
                            sclk_r  <= 1'b0;
                            pcnt    <= '0;
                            bcnt    <= '0;
                            tx      <= wr ? {1'b1, addr, din} : {1'b0, addr, {DATA_W{1'b0}}};
                            c_state <= CMD;
                        end
                    end
                end
                ERR: begin
                    done    <= 1'b0;
                    err     <= 1'b0;
                    ready   <= 1'b1;
                    c_state <= IDLE;
                end
                DONE: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    c_state <= IDLE;
                end
                default: begin
                    rx <= rx_next;
                    if (pcnt == P_LAST) begin
                        pcnt   <= '0;
                        sclk_r <= 1'b0;
                        tx     <= {tx[TXW-2:0], 1'b0};
                        bcnt   <= bcnt + 1'b1;
                        case (c_state)
                            CMD: if (bcnt == B_ADDR) begin
                                bcnt    <= '0;
                                c_state <= wr_q ? WDATA : TA;
                            end
                            TA: begin
                                bcnt    <= '0;
                                c_state <= RDATA;
                            end
                            WDATA, RDATA: if (bcnt == B_DATA) begin
                                cs_n_r  <= 1'b1;
                                done    <= 1'b1;
                                tx      <= '0;
                                c_state <= DONE;
                                if (c_state == RDATA)
                                    dout <= rx_next;
                            end
                            default: ;
                        endcase
                    end else begin
                        pcnt <= pcnt + 1'b1;
                        if (pcnt == P_HI)
                            sclk_r <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Memory slave FSM: decodes the link by sclk edge detection, owns the register array
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state   <= M_IDLE;
            cs_prev   <= 1'b1;
            sclk_prev <= 1'b0;
            m_cnt     <= '0;
            m_addr    <= '0;
            m_sh      <= '0;
            miso_r    <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            cs_prev   <= cs_n_r;
            sclk_prev <= sclk_r;
            if (cs_n_r) begin
                m_state <= M_IDLE;
                m_cnt   <= '0;
                miso_r  <= 1'b0;
            end else begin
                case (m_state)
                    M_IDLE: if (cs_prev) begin
                        m_cnt   <= '0;
                        m_state <= M_CMD;
                    end
                    M_CMD: if (s_rise) begin
                        // wr bit shifts out of the top on the last address bit
                        m_addr <= {m_addr[ADDR_W-2:0], mosi_w};
                        m_cnt  <= m_cnt + 1'b1;
                        if (m_cnt == B_ADDR) begin
                            m_cnt   <= '0;
                            m_state <= m_addr[ADDR_W-1] ? M_WDATA : M_TA;
                        end
                    end
                    M_WDATA: if (s_rise) begin
                        m_sh  <= {m_sh[DATA_W-2:0], mosi_w};
                        m_cnt <= m_cnt + 1'b1;
                        if (m_cnt == B_DATA) begin
                            if (m_ok)
                                mem[m_idx] <= {m_sh[DATA_W-2:0], mosi_w};
                            m_state <= M_IDLE;
                        end
                    end
                    M_TA: if (s_rise) begin
                        m_sh    <= m_ok ? mem[m_idx] : '0;
                        m_cnt   <= '0;
                        m_state <= M_RDATA;
                    end
                    M_RDATA: begin
                        if (s_fall) begin
                            miso_r <= m_sh[DATA_W-1];
                            m_sh   <= {m_sh[DATA_W-2:0], 1'b0};
                        end
                        if (s_rise) begin
                            m_cnt <= m_cnt + 1'b1;
                            if (m_cnt == B_DATA)
                                m_state <= M_IDLE;
                        end
                    end
                    default: m_state <= M_IDLE;
                endcase
            end
        end
    end

endmodule
